// File: rtl/keystone_pkg.sv
// Shared types and constants for the Keystone frame sequencer.
package keystone_pkg;

  localparam int COEF_W = 32;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } kfc_state_e;

  // Index 0 is H11 (LSBs), index 7 is H32.
  typedef logic [7:0][COEF_W-1:0] h_coef_t;

  localparam h_coef_t H_IDENTITY = {
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000
  };

endpackage

// File: rtl/keystone_pos_counter.sv
// Pixel x/y position tracking with line-end detection and EOL framing errors.
module keystone_pos_counter #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int XW       = 11,
  parameter int YW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  input  logic          sof,
  input  logic          advance,
  input  logic          tlast,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          frame_end,
  output logic          err_eol_early,
  output logic          err_eol_missing
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic at_x_last;
  logic line_end;

  // A line ends on tlast or on the last pixel position, whichever comes first.
  always_comb begin
    at_x_last = (x_pos == X_LAST);
    line_end  = advance & (tlast | at_x_last);
    frame_end = line_end & (y_pos == Y_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos           <= '0;
      y_pos           <= '0;
      err_eol_early   <= 1'b0;
      err_eol_missing <= 1'b0;
    end else if (!en) begin
      err_eol_early   <= 1'b0;
      err_eol_missing <= 1'b0;
    end else begin
      err_eol_early   <= advance & tlast & (x_pos < X_LAST);
      err_eol_missing <= advance & ~tlast & at_x_last;
      if (clear) begin
        x_pos <= '0;
        y_pos <= '0;
      end else if (sof) begin
        x_pos <= XW'(1);
        y_pos <= '0;
      end else if (line_end) begin
        x_pos <= '0;
        y_pos <= frame_end ? '0 : y_pos + YW'(1);
      end else if (advance) begin
        x_pos <= x_pos + XW'(1);
      end
    end
  end

endmodule

// File: rtl/keystone_frame_ctrl.sv
// Keystone frame sequencer: flush sequencing, frame FSM and frame-synchronous
// double-buffering of the homography coefficients.
module keystone_frame_ctrl
  import keystone_pkg::*;
#(
  parameter int H_ACTIVE     = 1920,
  parameter int V_ACTIVE     = 1080,
  parameter int XW           = 11,
  parameter int YW           = 11,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          aclken,
  input  logic          axis_tvalid,
  input  logic          axis_tready,
  input  logic          axis_tuser,
  input  logic          axis_tlast,
  input  h_coef_t       cfg_h,
  input  logic          cfg_enable,
  input  logic          cfg_commit,
  input  logic          sw_reset,
  output h_coef_t       h_active,
  output logic          keystone_en,
  output logic          datapath_rst,
  output logic          frame_start,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          commit_pending,
  output logic [15:0]   frame_count,
  output logic          err_sof_missing,
  output logic          err_eol_early,
  output logic          err_eol_missing,
  output logic          err_frame_short
);

  localparam logic [1:0] ST_FLUSH  = 2'(FLUSH);
  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACTIVE = 2'(ACTIVE);

  localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);

  logic [1:0]     state;
  logic [FCW-1:0] flush_cnt;
  h_coef_t        shadow_h;
  logic           shadow_en;

  logic beat;
  logic sof;
  logic advance;
  logic sof_miss;
  logic frame_end;

  // sw_reset outranks any beat arriving in the same cycle.
  always_comb begin
    beat     = aclken & axis_tvalid & axis_tready;
    sof      = beat & axis_tuser & ~sw_reset & ((state == ST_IDLE) | (state == ST_ACTIVE));
    advance  = beat & ~axis_tuser & ~sw_reset & (state == ST_ACTIVE);
    sof_miss = beat & ~axis_tuser & ~sw_reset & (state == ST_IDLE);
  end

  keystone_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pos (
    .clk             (aclk),
    .rst             (areset),
    .en              (aclken),
    .clear           (sw_reset),
    .sof             (sof),
    .advance         (advance),
    .tlast           (axis_tlast),
    .x_pos           (x_pos),
    .y_pos           (y_pos),
    .frame_end       (frame_end),
    .err_eol_early   (err_eol_early),
    .err_eol_missing (err_eol_missing)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state           <= ST_FLUSH;
      flush_cnt       <= FLUSH_LOAD;
      datapath_rst    <= 1'b1;
      h_active        <= H_IDENTITY;
      keystone_en     <= 1'b0;
      shadow_h        <= H_IDENTITY;
      shadow_en       <= 1'b0;
      commit_pending  <= 1'b0;
      frame_count     <= '0;
      frame_start     <= 1'b0;
      err_sof_missing <= 1'b0;
      err_frame_short <= 1'b0;
    end else if (!aclken) begin
      frame_start     <= 1'b0;
      err_sof_missing <= 1'b0;
      err_frame_short <= 1'b0;
    end else begin
      frame_start     <= sof;
      err_sof_missing <= sof_miss;
      err_frame_short <= sof & (state == ST_ACTIVE);

      if (cfg_commit) begin
        shadow_h       <= cfg_h;
        shadow_en      <= cfg_enable;
        commit_pending <= 1'b1;
      end
      // Coefficients only ever change on a start-of-frame beat; a commit in
      // the same cycle bypasses the shadow so it is not lost.
      if (sof && (commit_pending || cfg_commit)) begin
        h_active       <= cfg_commit ? cfg_h : shadow_h;
        keystone_en    <= cfg_commit ? cfg_enable : shadow_en;
        commit_pending <= 1'b0;
      end

      if (sw_reset) begin
        state        <= ST_FLUSH;
        flush_cnt    <= FLUSH_LOAD;
        datapath_rst <= 1'b1;
      end else begin
        case (state)
          ST_FLUSH: begin
            if (flush_cnt <= FCW'(1)) begin
              state        <= ST_IDLE;
              flush_cnt    <= '0;
              datapath_rst <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - FCW'(1);
            end
          end
          ST_IDLE: begin
            if (sof) state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (frame_end) begin
              state       <= ST_IDLE;
              frame_count <= frame_count + 16'd1;
            end
          end
          default: begin
            state        <= ST_FLUSH;
            flush_cnt    <= FLUSH_LOAD;
            datapath_rst <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keystone_frame_ctrl.sv
// Directed plus randomized bench for keystone_frame_ctrl against a frame-level
// behavioural model (small geometry: 8x4 frame, 4-cycle flush).
module tb_keystone_frame_ctrl;
  import keystone_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int F  = 4;
  localparam int XW = 11;
  localparam int YW = 11;

  logic          aclk = 1'b0;
  logic          areset;
  logic          aclken;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;
  h_coef_t       cfg_h;
  logic          cfg_enable;
  logic          cfg_commit;
  logic          sw_reset;
  h_coef_t       h_active;
  logic          keystone_en;
  logic          datapath_rst;
  logic          frame_start;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          commit_pending;
  logic [15:0]   frame_count;
  logic          err_sof_missing;
  logic          err_eol_early;
  logic          err_eol_missing;
  logic          err_frame_short;

  int tests = 0;
  int fails = 0;

  // Reference model: frame-level view of the sequencer.
  bit      m_flushing;
  int      m_flush_left;
  bit      m_in_frame;
  int      m_x;
  int      m_y;
  int      m_frames;
  h_coef_t m_h;
  h_coef_t m_shadow;
  bit      m_en;
  bit      m_shadow_en;
  bit      m_pending;
  bit      e_fs;
  bit      e_sof_miss;
  bit      e_early;
  bit      e_missing;
  bit      e_short;

  always #5 aclk = ~aclk;

  keystone_frame_ctrl #(
    .H_ACTIVE     (H),
    .V_ACTIVE     (V),
    .XW           (XW),
    .YW           (YW),
    .FLUSH_CYCLES (F)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .aclken          (aclken),
    .axis_tvalid     (tvalid),
    .axis_tready     (tready),
    .axis_tuser      (tuser),
    .axis_tlast      (tlast),
    .cfg_h           (cfg_h),
    .cfg_enable      (cfg_enable),
    .cfg_commit      (cfg_commit),
    .sw_reset        (sw_reset),
    .h_active        (h_active),
    .keystone_en     (keystone_en),
    .datapath_rst    (datapath_rst),
    .frame_start     (frame_start),
    .x_pos           (x_pos),
    .y_pos           (y_pos),
    .commit_pending  (commit_pending),
    .frame_count     (frame_count),
    .err_sof_missing (err_sof_missing),
    .err_eol_early   (err_eol_early),
    .err_eol_missing (err_eol_missing),
    .err_frame_short (err_frame_short)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_flushing   = 1'b1;
    m_flush_left = F;
    m_in_frame   = 1'b0;
    m_x          = 0;
    m_y          = 0;
    m_frames     = 0;
    m_h          = H_IDENTITY;
    m_shadow     = H_IDENTITY;
    m_en         = 1'b0;
    m_shadow_en  = 1'b0;
    m_pending    = 1'b0;
    {e_fs, e_sof_miss, e_early, e_missing, e_short} = '0;
  endtask

  // One clock edge of the frame-level rules, using the inputs currently driven.
  task automatic modelStep();
    bit beat, sof, adv, apply;
    {e_fs, e_sof_miss, e_early, e_missing, e_short} = '0;
    if (!aclken) return;
    beat       = tvalid && tready;
    sof        = !m_flushing && beat && tuser && !sw_reset;
    adv        = m_in_frame && beat && !tuser && !sw_reset;
    e_fs       = sof;
    e_sof_miss = !m_flushing && !m_in_frame && beat && !tuser && !sw_reset;
    e_short    = m_in_frame && sof;
    e_early    = adv && tlast && (m_x < H - 1);
    e_missing  = adv && !tlast && (m_x == H - 1);
    apply      = sof && (m_pending || cfg_commit);
    if (apply) begin
      m_h  = cfg_commit ? cfg_h : m_shadow;
      m_en = cfg_commit ? cfg_enable : m_shadow_en;
    end
    if (cfg_commit) begin
      m_shadow    = cfg_h;
      m_shadow_en = cfg_enable;
    end
    m_pending = apply ? 1'b0 : (cfg_commit ? 1'b1 : m_pending);
    if (sw_reset) begin
      m_flushing   = 1'b1;
      m_flush_left = F;
      m_in_frame   = 1'b0;
      m_x          = 0;
      m_y          = 0;
    end else if (m_flushing) begin
      m_flush_left--;
      if (m_flush_left <= 0) m_flushing = 1'b0;
    end else if (sof) begin
      m_in_frame = 1'b1;
      m_x        = 1;
      m_y        = 0;
    end else if (adv) begin
      if (tlast || m_x == H - 1) begin
        m_x = 0;
        if (m_y == V - 1) begin
          m_frames++;
          m_in_frame = 1'b0;
          m_y        = 0;
        end else begin
          m_y++;
        end
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic checkOutput();
    chk("datapath_rst", datapath_rst, m_flushing);
    chk("x_pos", x_pos, m_x);
    chk("y_pos", y_pos, m_y);
    chk("frame_count", frame_count, m_frames & 16'hFFFF);
    chk("frame_start", frame_start, e_fs);
    chk("err_sof_missing", err_sof_missing, e_sof_miss);
    chk("err_eol_early", err_eol_early, e_early);
    chk("err_eol_missing", err_eol_missing, e_missing);
    chk("err_frame_short", err_frame_short, e_short);
    chk("h_active", h_active, m_h);
    chk("keystone_en", keystone_en, m_en);
    chk("commit_pending", commit_pending, m_pending);
  endtask

  task automatic applyStimulus(input bit en, input bit v, input bit r, input bit u,
                               input bit l, input bit c, input bit s);
    aclken     = en;
    tvalid     = v;
    tready     = r;
    tuser      = u;
    tlast      = l;
    cfg_commit = c;
    sw_reset   = s;
    @(posedge aclk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic sendBeat(input bit u, input bit l);
    applyStimulus(1'b1, 1'b1, 1'b1, u, l, 1'b0, 1'b0);
  endtask

  initial begin
    h_coef_t h_committed;
    int      cnt;
    int      errs;
    int      beats;
    int      fc_before;

    areset = 1'b1;
    {aclken, tvalid, tready, tuser, tlast, cfg_enable, cfg_commit, sw_reset} = '0;
    aclken = 1'b1;
    cfg_h  = H_IDENTITY;
    modelReset();

    // Reset: state held during reset, then exactly F cycles of datapath_rst.
    repeat (3) @(posedge aclk);
    #1;
    checkOutput();
    chk("t1_h_identity", h_active, H_IDENTITY);
    areset = 1'b0;
    cnt = int'(datapath_rst);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cnt += int'(datapath_rst);
    end
    chk("t1_rst_cycles", cnt, F);

    // Clean frame: 32 beats, SOF on beat 0, tlast every 8th.
    cnt  = 0;
    errs = 0;
    for (int b = 0; b < 32; b++) begin
      sendBeat(b == 0, (b % 8) == 7);
      cnt  += int'(frame_start);
      errs += int'(err_sof_missing) + int'(err_eol_early) + int'(err_eol_missing) + int'(err_frame_short);
    end
    chk("t2_frame_start_count", cnt, 1);
    chk("t2_err_count", errs, 0);
    chk("t2_frame_count", frame_count, 16'd1);
    chk("t2_x_idle", x_pos, 0);
    chk("t2_y_idle", y_pos, 0);

    // Commit mid-frame; coefficients only move at the following SOF.
    h_committed    = H_IDENTITY;
    h_committed[2] = 32'h0000_0A00;
    for (int b = 0; b < 32; b++) begin
      if (b == 12) begin
        cfg_h      = h_committed;
        cfg_enable = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cfg_h      = {8{32'hDEAD_BEEF}};
        cfg_enable = 1'b0;
        chk("t3_pending_set", commit_pending, 1'b1);
      end else begin
        sendBeat(b == 0, (b % 8) == 7);
      end
      chk("t3_h_unchanged", h_active, H_IDENTITY);
    end
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_h_still_old", h_active, H_IDENTITY);
    sendBeat(1'b1, 1'b0);
    chk("t3_h_applied", h_active, h_committed);
    chk("t3_en_applied", keystone_en, 1'b1);
    chk("t3_pending_clear", commit_pending, 1'b0);
    for (int b = 1; b < 32; b++) sendBeat(1'b0, (b % 8) == 7);

    // Framing errors: early EOL, missing EOL, short frame.
    sendBeat(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sendBeat(1'b0, 1'b0);
    sendBeat(1'b0, 1'b1);
    chk("t4_eol_early", err_eol_early, 1'b1);
    chk("t4_y_after_early", y_pos, 1);
    for (int i = 0; i < 8; i++) sendBeat(1'b0, 1'b0);
    chk("t4_eol_missing", err_eol_missing, 1'b1);
    chk("t4_x_wrap", x_pos, 0);
    chk("t4_y_after_missing", y_pos, 2);
    sendBeat(1'b0, 1'b0);
    sendBeat(1'b0, 1'b0);
    sendBeat(1'b1, 1'b0);
    chk("t4_frame_short", err_frame_short, 1'b1);
    chk("t4_restart_fs", frame_start, 1'b1);
    chk("t4_restart_x", x_pos, 1);
    chk("t4_restart_y", y_pos, 0);
    for (int b = 1; b < 32; b++) sendBeat(1'b0, (b % 8) == 7);

    // sw_reset mid-line at x=3,y=1; beats ignored while flushing.
    sendBeat(1'b1, 1'b0);
    for (int b = 1; b < 8; b++) sendBeat(1'b0, b == 7);
    repeat (3) sendBeat(1'b0, 1'b0);
    chk("t5_x_before", x_pos, 3);
    chk("t5_y_before", y_pos, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cnt = int'(datapath_rst);
    chk("t5_x_cleared", x_pos, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, i == 1, 1'b0, 1'b0, 1'b0);
      cnt += int'(datapath_rst);
    end
    chk("t5_flush_cycles", cnt, F);
    chk("t5_h_kept", h_active, h_committed);
    sendBeat(1'b1, 1'b0);
    chk("t5_sof_accepted", frame_start, 1'b1);
    for (int b = 1; b < 32; b++) sendBeat(1'b0, (b % 8) == 7);

    // Clean frame with aclken toggling; junk on the bus while disabled.
    fc_before = m_frames;
    beats     = 0;
    cnt       = 0;
    for (int c = 0; c < 400 && beats < 32; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        sendBeat(beats == 0, (beats % 8) == 7);
        beats++;
      end else begin
        applyStimulus(1'b0, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      end
      cnt += int'(frame_start);
    end
    chk("t6_budget", beats, 32);
    chk("t6_frame_count", frame_count, 16'((fc_before + 1) & 16'hFFFF));
    chk("t6_frame_start_count", cnt, 1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 800; c++) begin
      bit u;
      for (int k = 0; k < 8; k++) cfg_h[k] = $urandom;
      cfg_enable = 1'($urandom);
      u = ($urandom_range(0, 99) < 8);
      applyStimulus($urandom_range(0, 9) < 8,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0,
                    u,
                    !u && ($urandom_range(0, 99) < 12),
                    $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
